// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART receiver state type, parity modes and divider math
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK_WAIT
  } rx_state_t;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  // Clocks per oversample tick, rounded to nearest.
  function automatic int calc_div(input longint clk_hz, input longint baud, input longint os);
    longint den;
    den = baud * os;
    return int'((clk_hz + den / 2) / den);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO; a pop frees room for a same-cycle push when full
module sync_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  // Head reads as zero when empty so the outputs are clean after reset.
  assign pop_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - oversampling UART receiver with majority vote feeding a receive FIFO
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 25000000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk_25M,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  input  logic                 ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int DIV   = calc_div(CLK_HZ, BAUD, OVERSAMPLE);
  localparam int DIV_W = (DIV > 2) ? $clog2(DIV) : 1;
  localparam int OS_W  = $clog2(OVERSAMPLE) + 1;
  localparam int BC_W  = $clog2(DATA_BITS + 1);
  localparam int WIDTH = DATA_BITS + 2;

  localparam logic [OS_W-1:0]  SMP_A     = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [OS_W-1:0]  SMP_B     = OS_W'(OVERSAMPLE / 2);
  localparam logic [OS_W-1:0]  SMP_C     = OS_W'(OVERSAMPLE / 2 + 1);
  localparam logic [OS_W-1:0]  BIT_END   = OS_W'(OVERSAMPLE);
  localparam logic [BC_W-1:0]  DATA_LAST = BC_W'(DATA_BITS - 1);
  localparam logic [BC_W-1:0]  STOP_LAST = BC_W'(STOP_BITS - 1);
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DIV - 1);

  if (DIV < 2) begin : g_bad_div
    $error("uart_rx_fifo: CLK_HZ/(BAUD*OVERSAMPLE) must round to at least 2");
  end
  if (OVERSAMPLE < 8 || OVERSAMPLE > 32 || (OVERSAMPLE % 2) != 0) begin : g_bad_os
    $error("uart_rx_fifo: OVERSAMPLE must be even, 8..32");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > 2 ||
      STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_frame
    $error("uart_rx_fifo: unsupported frame format");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_rx_fifo: FIFO_DEPTH must be a power of 2, at least 2");
  end

  rx_state_t            state, state_next;
  logic                 rx_meta, rx_s;
  logic [DIV_W-1:0]     div_cnt;
  logic                 tick, div_restart;
  logic [OS_W-1:0]      os_cnt, os_next, idx;
  logic [BC_W-1:0]      bit_cnt, bit_next;
  logic [1:0]           smp, smp_next;
  logic                 vote;
  logic [DATA_BITS-1:0] shift_reg, shift_next;
  logic                 perr_r, perr_next;
  logic                 ferr_r, ferr_next;
  logic                 push_q, push_next;
  logic [WIDTH-1:0]     head;
  logic                 full, empty;

  assign tick = (div_cnt == DIV_LAST);
  assign idx  = os_cnt + 1'b1;
  assign vote = (smp[0] & smp[1]) | (smp[0] & rx_s) | (smp[1] & rx_s);
  assign busy = (state != ST_IDLE);

  always_comb begin
    state_next  = state;
    os_next     = os_cnt;
    bit_next    = bit_cnt;
    smp_next    = smp;
    shift_next  = shift_reg;
    perr_next   = perr_r;
    ferr_next   = ferr_r;
    push_next   = 1'b0;
    div_restart = 1'b0;
    case (state)
      ST_IDLE: begin
        if (tick && !rx_s) begin
          state_next  = ST_START;
          os_next     = '0;
          bit_next    = '0;
          perr_next   = 1'b0;
          ferr_next   = 1'b0;
          div_restart = 1'b1;
        end
      end
      ST_BREAK_WAIT: begin
        if (tick && rx_s) state_next = ST_IDLE;
      end
      default: begin
        if (state == ST_STOP && push_q) begin
          state_next = ferr_r ? ST_BREAK_WAIT : ST_IDLE;
        end else if (tick) begin
          os_next = idx;
          if (idx == SMP_A) smp_next[0] = rx_s;
          if (idx == SMP_B) smp_next[1] = rx_s;
          // Third sample completes the vote; act on the bit at mid-point.
          if (idx == SMP_C) begin
            case (state)
              ST_START:  if (vote) state_next = ST_IDLE;
              ST_DATA:   shift_next = {vote, shift_reg[DATA_BITS-1:1]};
              ST_PARITY: perr_next = (PARITY == PARITY_EVEN) ? (^shift_reg ^ vote)
                                                             : ~(^shift_reg ^ vote);
              ST_STOP: begin
                if (!vote) ferr_next = 1'b1;
                if (bit_cnt == STOP_LAST) push_next = 1'b1;
              end
              default: ;
            endcase
          end
          if (idx == BIT_END) begin
            os_next = '0;
            case (state)
              ST_START: begin
                state_next = ST_DATA;
                bit_next   = '0;
              end
              ST_DATA: begin
                if (bit_cnt == DATA_LAST) begin
                  bit_next   = '0;
                  state_next = (PARITY == PARITY_NONE) ? ST_STOP : ST_PARITY;
                end else begin
                  bit_next = bit_cnt + 1'b1;
                end
              end
              ST_PARITY: begin
                state_next = ST_STOP;
                bit_next   = '0;
              end
              ST_STOP: bit_next = bit_cnt + 1'b1;
              default: ;
            endcase
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk_25M or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      rx_meta   <= 1'b1;
      rx_s      <= 1'b1;
      div_cnt   <= '0;
      os_cnt    <= '0;
      bit_cnt   <= '0;
      smp       <= 2'b11;
      shift_reg <= '0;
      perr_r    <= 1'b0;
      ferr_r    <= 1'b0;
      push_q    <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state     <= state_next;
      rx_meta   <= rx;
      rx_s      <= rx_meta;
      div_cnt   <= (tick || div_restart) ? '0 : div_cnt + 1'b1;
      os_cnt    <= os_next;
      bit_cnt   <= bit_next;
      smp       <= smp_next;
      shift_reg <= shift_next;
      perr_r    <= perr_next;
      ferr_r    <= ferr_next;
      push_q    <= push_next;
      overrun   <= push_q && full && !ready;
    end
  end

  sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk_25M),
    .rst_n     (rst_n),
    .push      (push_q),
    .push_data ({perr_r, ferr_r, shift_reg}),
    .pop       (ready),
    .pop_data  (head),
    .full      (full),
    .empty     (empty)
  );

  assign valid      = !empty;
  assign data       = head[DATA_BITS-1:0];
  assign frame_err  = head[DATA_BITS];
  assign parity_err = head[DATA_BITS+1];

endmodule
